lsp_pre_select: RTL and testbench

Stage of the G.729 LSP quantizer (Qua_Lsp) that runs directly upstream of `lsp_select_2`. It performs the first-stage codebook pre-selection: it scans all 128 ten-element codewords of `lspcb1` against the target vector `rbuf` and finds the codeword with the minimum squared Euclidean distance. It writes the winning index `cand` to scratch memory and also presents it on a port. The next stage derives `lspcb1Addr` from `cand`. Arithmetic uses the shared ETSI basic-op units (`sub`, `L_mac`, `L_sub`) through out/in port pairs, matching the other Qua_Lsp FSMs.

---
 rtl/lsp_pre_select_if.sv | 36 +++
 rtl/lsp_pre_select.sv | 158 +++++++++++++++
 tb/tb_lsp_pre_select.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsp_pre_select_if.sv
// Handshake, memory and shared basic-op signal bundle of the LSP first-stage
// pre-selection block.
interface lsp_pre_select_if;
  logic        start;
  logic        done;
  logic [6:0]  cand;
  logic [11:0] memReadAddr;
  logic [31:0] memIn;
  logic [11:0] constMemAddr;
  logic [31:0] constMemIn;
  logic        memWriteEn;
  logic [11:0] memWriteAddr;
  logic [31:0] memOut;
  logic [15:0] subOutA;
  logic [15:0] subOutB;
  logic [15:0] subIn;
  logic [15:0] L_macOutA;
  logic [15:0] L_macOutB;
  logic [31:0] L_macOutC;
  logic [31:0] L_macIn;
  logic [31:0] L_subOutA;
  logic [31:0] L_subOutB;
  logic [31:0] L_subIn;

  modport slave (
    input  start, memIn, constMemIn, subIn, L_macIn, L_subIn,
    output done, cand, memReadAddr, constMemAddr, memWriteEn, memWriteAddr, memOut,
           subOutA, subOutB, L_macOutA, L_macOutB, L_macOutC, L_subOutA, L_subOutB
  );

  modport master (
    output start, memIn, constMemIn, subIn, L_macIn, L_subIn,
    input  done, cand, memReadAddr, constMemAddr, memWriteEn, memWriteAddr, memOut,
           subOutA, subOutB, L_macOutA, L_macOutB, L_macOutC, L_subOutA, L_subOutB
  );
endinterface

// File: rtl/lsp_pre_select.sv
// First-stage LSP codebook pre-selection: scans 128 ten-element codewords and
// keeps the index with the smallest squared distance to rbuf.
module lsp_pre_select #(
  parameter logic [11:0] RBUF_ADDR   = 12'd0,
  parameter logic [11:0] LSPCB1_ADDR = 12'd0,
  parameter logic [11:0] CAND_ADDR   = 12'd0
) (
  input  logic           clk,
  input  logic           reset,
  lsp_pre_select_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ADDR, S_DATA, S_CMP, S_WRITE, S_DONE
  } state_t;

  state_t      r_state;
  logic [6:0]  r_i;
  logic [3:0]  r_j;
  logic [11:0] r_ptr;
  logic [31:0] r_l_tmp;
  logic [31:0] r_l_dmin;
  logic [6:0]  r_cand;
  logic [11:0] r_mem_read_addr;
  logic [11:0] r_const_mem_addr;
  logic        r_mem_write_en;
  logic [11:0] r_mem_write_addr;
  logic [31:0] r_mem_out;
  logic        r_done;

  logic        w_closer;
  logic [6:0]  w_cand_next;
  logic [3:0]  w_j_next;
  logic [11:0] w_ptr_next;
  logic        w_unused;

  // A negative L_sub result means strictly closer; ties keep the earlier index.
  assign w_closer    = bus.L_subIn[31];
  assign w_cand_next = w_closer ? r_i : r_cand;
  assign w_j_next    = r_j + 4'd1;
  assign w_ptr_next  = r_ptr + 12'd1;
  assign w_unused    = ^{bus.memIn[31:16], bus.constMemIn[31:16], bus.L_subIn[30:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_i              <= '0;
      r_j              <= '0;
      r_ptr            <= '0;
      r_l_tmp          <= '0;
      r_l_dmin         <= '0;
      r_cand           <= '0;
      r_mem_read_addr  <= '0;
      r_const_mem_addr <= '0;
      r_mem_write_en   <= 1'b0;
      r_mem_write_addr <= '0;
      r_mem_out        <= '0;
      r_done           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) r_state <= S_INIT;
        end
        S_INIT: begin
          r_i              <= '0;
          r_j              <= '0;
          r_l_tmp          <= '0;
          r_l_dmin         <= 32'h7FFF_FFFF;
          r_cand           <= '0;
          r_ptr            <= LSPCB1_ADDR;
          r_mem_read_addr  <= RBUF_ADDR;
          r_const_mem_addr <= LSPCB1_ADDR;
          r_state          <= S_ADDR;
        end
        S_ADDR: begin
          r_mem_read_addr  <= '0;
          r_const_mem_addr <= '0;
          r_state          <= S_DATA;
        end
        S_DATA: begin
          r_l_tmp <= bus.L_macIn;
          r_ptr   <= w_ptr_next;
          if (r_j == 4'd9) begin
            r_j     <= '0;
            r_state <= S_CMP;
          end else begin
            // Addresses are set up one edge early so they are live during ADDR.
            r_j              <= w_j_next;
            r_mem_read_addr  <= RBUF_ADDR + {8'd0, w_j_next};
            r_const_mem_addr <= w_ptr_next;
            r_state          <= S_ADDR;
          end
        end
        S_CMP: begin
          if (w_closer) begin
            r_l_dmin <= r_l_tmp;
            r_cand   <= r_i;
          end
          r_l_tmp <= '0;
          if (r_i == 7'd127) begin
            r_mem_write_en   <= 1'b1;
            r_mem_write_addr <= CAND_ADDR;
            r_mem_out        <= {25'd0, w_cand_next};
            r_state          <= S_WRITE;
          end else begin
            r_i              <= r_i + 7'd1;
            r_mem_read_addr  <= RBUF_ADDR;
            r_const_mem_addr <= r_ptr;
            r_state          <= S_ADDR;
          end
        end
        S_WRITE: begin
          r_mem_write_en   <= 1'b0;
          r_mem_write_addr <= '0;
          r_mem_out        <= '0;
          r_done           <= 1'b1;
          r_state          <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operands flow combinationally through the shared basic-op units.
  always_comb begin
    bus.subOutA   = '0;
    bus.subOutB   = '0;
    bus.L_macOutA = '0;
    bus.L_macOutB = '0;
    bus.L_macOutC = '0;
    bus.L_subOutA = '0;
    bus.L_subOutB = '0;
    if (r_state == S_DATA) begin
      bus.subOutA   = bus.memIn[15:0];
      bus.subOutB   = bus.constMemIn[15:0];
      bus.L_macOutA = bus.subIn;
      bus.L_macOutB = bus.subIn;
      bus.L_macOutC = r_l_tmp;
    end
    if (r_state == S_CMP) begin
      bus.L_subOutA = r_l_tmp;
      bus.L_subOutB = r_l_dmin;
    end
  end

  assign bus.done         = r_done;
  assign bus.cand         = r_cand;
  assign bus.memReadAddr  = r_mem_read_addr;
  assign bus.constMemAddr = r_const_mem_addr;
  assign bus.memWriteEn   = r_mem_write_en;
  assign bus.memWriteAddr = r_mem_write_addr;
  assign bus.memOut       = r_mem_out;

endmodule

// File: tb/tb_lsp_pre_select.sv
// Directed-vector bench for lsp_pre_select with behavioural memories and
// saturating basic-op units.
module tb_lsp_pre_select;

  localparam logic [11:0] RB = 12'h010;
  localparam logic [11:0] CB = 12'h100;
  localparam logic [11:0] CA = 12'h020;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  logic [31:0] scratch [0:4095];
  logic [31:0] cmem    [0:4095];
  logic [31:0] mem_q;
  logic [31:0] cmem_q;
  int          wr_count;
  logic [11:0] wr_addr_last;
  logic [31:0] wr_data_last;

  lsp_pre_select_if bus ();

  lsp_pre_select #(
    .RBUF_ADDR  (RB),
    .LSPCB1_ADDR(CB),
    .CAND_ADDR  (CA)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sat32(input longint s);
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return 32'(s);
  endfunction

  function automatic logic [15:0] f_sub(input logic [15:0] a, input logic [15:0] b);
    int d;
    d = int'($signed(a)) - int'($signed(b));
    if (d > 32767) return 16'h7FFF;
    if (d < -32768) return 16'h8000;
    return 16'(d);
  endfunction

  function automatic logic [31:0] f_l_mac(input logic [31:0] c, input logic [15:0] a,
                                          input logic [15:0] b);
    longint p;
    if (a == 16'h8000 && b == 16'h8000) p = 64'sd2147483647;
    else p = 2 * longint'($signed(a)) * longint'($signed(b));
    return sat32(longint'($signed(c)) + p);
  endfunction

  function automatic logic [31:0] f_l_sub(input logic [31:0] a, input logic [31:0] b);
    return sat32(longint'($signed(a)) - longint'($signed(b)));
  endfunction

  assign bus.memIn      = mem_q;
  assign bus.constMemIn = cmem_q;
  assign bus.subIn      = f_sub(bus.subOutA, bus.subOutB);
  assign bus.L_macIn    = f_l_mac(bus.L_macOutC, bus.L_macOutA, bus.L_macOutB);
  assign bus.L_subIn    = f_l_sub(bus.L_subOutA, bus.L_subOutB);

  always @(posedge clk) begin
    mem_q  <= scratch[bus.memReadAddr];
    cmem_q <= cmem[bus.constMemAddr];
    if (bus.memWriteEn) begin
      wr_count     <= wr_count + 1;
      wr_addr_last <= bus.memWriteAddr;
      wr_data_last <= bus.memOut;
    end
  end

  task automatic load_rbuf(input int base, input int step, input logic [15:0] upper);
    for (int j = 0; j < 10; j++) scratch[RB + 12'(j)] = {upper, 16'(base + step * j)};
  endtask

  task automatic set_row(input int i, input int base, input int step, input int bump_idx,
                         input int bump);
    for (int j = 0; j < 10; j++)
      cmem[CB + 12'(10 * i + j)] = {16'hDEAD, 16'(base + step * j + ((j == bump_idx) ? bump : 0))};
  endtask

  task automatic run_search(input bit hold, output int lat, output int pulses);
    lat = -1;
    pulses = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    for (int k = 1; k <= 2760; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k + 1;
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_vec++; if (bus.cand !== 7'd0) begin n_err++; $display("FAIL reset_cand got=%0d exp=0", bus.cand); end
    n_vec++; if (bus.memWriteEn !== 1'b0) begin n_err++; $display("FAIL reset_wen got=%b exp=0", bus.memWriteEn); end
    n_vec++; if ({bus.memReadAddr, bus.constMemAddr, bus.memWriteAddr} !== 36'd0) begin
      n_err++; $display("FAIL reset_addr got=%h exp=0", {bus.memReadAddr, bus.constMemAddr, bus.memWriteAddr}); end
    n_vec++; if ({bus.memOut, bus.L_macOutC, bus.L_subOutA, bus.subOutA} !== 112'd0) begin
      n_err++; $display("FAIL reset_data got=%h exp=0", {bus.memOut, bus.L_macOutC, bus.L_subOutA, bus.subOutA}); end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_vec++; if ({bus.done, bus.memWriteEn, bus.memReadAddr, bus.constMemAddr} !== 26'd0) begin
      n_err++; $display("FAIL idle_outputs got=%h exp=0", {bus.done, bus.memWriteEn, bus.memReadAddr, bus.constMemAddr}); end
  endtask

  task automatic setup_row37;
    load_rbuf(0, 0, 16'h0000);
    for (int i = 0; i < 128; i++) set_row(i, 0, 0, 0, (i == 37) ? 0 : 100);
  endtask

  task automatic test_single_zero_row;
    int lat, pulses, w0;
    setup_row37();
    w0 = wr_count;
    run_search(1'b0, lat, pulses);
    n_vec++; if (bus.cand !== 7'd37) begin n_err++; $display("FAIL row37_cand got=%0d exp=37", bus.cand); end
    n_vec++; if (wr_data_last !== 32'd37) begin n_err++; $display("FAIL row37_mem got=%0d exp=37", wr_data_last); end
    n_vec++; if (lat !== 2691) begin n_err++; $display("FAIL row37_latency got=%0d exp=2691", lat); end
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL row37_pulses got=%0d exp=1", pulses); end
    n_vec++; if (wr_count - w0 !== 1) begin n_err++; $display("FAIL row37_writes got=%0d exp=1", wr_count - w0); end
  endtask

  task automatic test_tie;
    int lat, pulses;
    load_rbuf(-300, 100, 16'hABCD);
    for (int i = 0; i < 128; i++) set_row(i, -300, 100, 0, 0);
    for (int i = 0; i < 128; i++)
      if (i != 5 && i != 90)
        for (int j = 0; j < 10; j++) cmem[CB + 12'(10 * i + j)] = {16'h0, 16'(-300 + 100 * j + 1)};
    run_search(1'b0, lat, pulses);
    n_vec++; if (bus.cand !== 7'd5) begin n_err++; $display("FAIL tie_cand got=%0d exp=5", bus.cand); end
    n_vec++; if (wr_data_last !== 32'd5) begin n_err++; $display("FAIL tie_mem got=%0d exp=5", wr_data_last); end
  endtask

  task automatic test_last_row;
    int lat, pulses;
    load_rbuf(-1000, 37, 16'h0000);
    for (int i = 0; i < 128; i++) set_row(i, -1000, 37, 3, (i == 127) ? 0 : 5);
    run_search(1'b0, lat, pulses);
    n_vec++; if (bus.cand !== 7'd127) begin n_err++; $display("FAIL last_cand got=%0d exp=127", bus.cand); end
    n_vec++; if (wr_data_last !== 32'd127) begin n_err++; $display("FAIL last_mem got=%0d exp=127", wr_data_last); end
  endtask

  task automatic test_saturation;
    int lat, pulses;
    for (int j = 0; j < 10; j++) scratch[RB + 12'(j)] = 32'h0000_7FFF;
    for (int k = 0; k < 1280; k++) cmem[CB + 12'(k)] = 32'h0000_8000;
    run_search(1'b0, lat, pulses);
    n_vec++; if (bus.cand !== 7'd0) begin n_err++; $display("FAIL sat_cand got=%0d exp=0", bus.cand); end
    n_vec++; if (wr_data_last !== 32'd0) begin n_err++; $display("FAIL sat_mem got=%0d exp=0", wr_data_last); end
    n_vec++; if (lat !== 2691) begin n_err++; $display("FAIL sat_latency got=%0d exp=2691", lat); end
  endtask

  task automatic test_reset_mid_search;
    int lat, pulses, w0, bad;
    setup_row37();
    w0 = wr_count;
    bad = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (998) @(posedge clk);
    #1;
    n_vec++; if (bus.cand !== 7'd37) begin n_err++; $display("FAIL mid_cand_before got=%0d exp=37", bus.cand); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_vec++; if (bus.cand !== 7'd0) begin n_err++; $display("FAIL mid_cand_after got=%0d exp=0", bus.cand); end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2800; k++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.memWriteEn !== 1'b0 || bus.memReadAddr !== 12'd0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL mid_quiet got=%0d active cycles exp=0", bad); end
    n_vec++; if (wr_count !== w0) begin n_err++; $display("FAIL mid_writes got=%0d exp=%0d", wr_count, w0); end
    run_search(1'b0, lat, pulses);
    n_vec++; if (bus.cand !== 7'd37) begin n_err++; $display("FAIL mid_restart_cand got=%0d exp=37", bus.cand); end
    n_vec++; if (lat !== 2691) begin n_err++; $display("FAIL mid_restart_latency got=%0d exp=2691", lat); end
  endtask

  task automatic test_start_held;
    int lat, pulses, w0;
    setup_row37();
    w0 = wr_count;
    run_search(1'b1, lat, pulses);
    n_vec++; if (lat !== 2691) begin n_err++; $display("FAIL held_latency got=%0d exp=2691", lat); end
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
    n_vec++; if (wr_count - w0 !== 1) begin n_err++; $display("FAIL held_writes got=%0d exp=1", wr_count - w0); end
    n_vec++; if (wr_addr_last !== CA) begin n_err++; $display("FAIL held_waddr got=%h exp=%h", wr_addr_last, CA); end
    n_vec++; if (bus.cand !== 7'd37) begin n_err++; $display("FAIL held_cand got=%0d exp=37", bus.cand); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    wr_count = 0;
    wr_addr_last = '0;
    wr_data_last = '0;
    bus.start = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 4096; k++) begin
      scratch[k] = '0;
      cmem[k] = '0;
    end
    test_reset();
    test_single_zero_row();
    test_tie();
    test_reset_mid_search();
    test_last_row();
    test_saturation();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
